polygon_edge_builder: RTL and testbench

- Upstream feeder for the per-pixel edge-crossing units. Accepts a polygon as a stream of vertices, forms closed-loop edges and packs each edge into the 38-bit line word the crossing units consume.
- Edges are built in a shadow bank. The shadow bank is copied to the active bank only at a frame boundary, so the crossing units never see a half-built polygon mid-frame.

---
 rtl/polygon_edge_builder.sv | 192 +++++++++++++++++++
 tb/tb_polygon_edge_builder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/polygon_edge_builder.sv
// Polygon vertex stream -> closed-loop edge lines, built in a shadow bank and committed at frame_start.
// Optional POLY_HORIZ_SKIP_EN: horizontal edges (y1==y2) are dropped and consume no slot.

module polygon_edge_slot (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        wr,
  input  logic        commit,
  input  logic [37:0] wr_line,
  output logic [37:0] line,
  output logic        en,
  output logic        sh_en
);
  logic [37:0] sh_line;

  // commit samples the pre-clear shadow, so commit+clear in one cycle is safe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_line <= '0;
      sh_en   <= 1'b0;
      line    <= '0;
      en      <= 1'b0;
    end else begin
      if (commit) begin
        line <= sh_line;
        en   <= sh_en;
      end
      if (clear) begin
        sh_line <= '0;
        sh_en   <= 1'b0;
      end else if (wr) begin
        sh_line <= wr_line;
        sh_en   <= 1'b1;
      end
    end
  end
endmodule

module polygon_edge_builder #(
  parameter int MAX_EDGES = 8,
  parameter int CNT_W     = $clog2(MAX_EDGES+1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    vtx_valid,
  output logic                    vtx_ready,
  input  logic [9:0]              vtx_x,
  input  logic [8:0]              vtx_y,
  input  logic                    vtx_last,
  input  logic                    frame_start,
  output logic [MAX_EDGES*38-1:0] edge_lines,
  output logic [MAX_EDGES-1:0]    edge_en,
  output logic [CNT_W-1:0]        edge_count,
  output logic                    busy,
  output logic                    error
);
  typedef enum logic [2:0] {IDLE, FIRST, COLLECT, CLOSE, PENDING} state_t;
  state_t state;

  logic [9:0]           first_x, prev_x;
  logic [8:0]           first_y, prev_y;
  logic [CNT_W-1:0]     idx;
  logic [1:0]           vcnt;
  logic                 ovf;
  logic [MAX_EDGES-1:0] sh_mask;
  logic [CNT_W-1:0]     pop;

  logic        accept, idx_free, clear, commit;
  logic        skip_cur, skip_close;
  logic        edge_wr;
  logic [37:0] edge_line, cur_line, close_line;

  assign vtx_ready  = (state == FIRST) || (state == COLLECT);
  assign busy       = (state != IDLE);
  assign accept     = vtx_valid && vtx_ready;
  assign idx_free   = (idx != CNT_W'(MAX_EDGES));
  assign clear      = start || (state == IDLE);
  assign commit     = (state == PENDING) && frame_start;
  assign cur_line   = {prev_x, prev_y, vtx_x, vtx_y};
  assign close_line = {prev_x, prev_y, first_x, first_y};

`ifdef POLY_HORIZ_SKIP_EN
  assign skip_cur   = (prev_y == vtx_y);
  assign skip_close = (prev_y == first_y);
`else
  assign skip_cur   = 1'b0;
  assign skip_close = 1'b0;
`endif

  always_comb begin
    edge_wr   = 1'b0;
    edge_line = cur_line;
    if (!start && state == COLLECT && accept && idx_free && !skip_cur)
      edge_wr = 1'b1;
    else if (!start && state == CLOSE && vcnt == 2'd3 && !ovf && idx_free && !skip_close) begin
      edge_wr   = 1'b1;
      edge_line = close_line;
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < MAX_EDGES; k++) pop = pop + CNT_W'(sh_mask[k]);
  end

  for (genvar k = 0; k < MAX_EDGES; k++) begin : g_slot
    polygon_edge_slot u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .wr      (edge_wr && (idx == CNT_W'(k))),
      .commit  (commit),
      .wr_line (edge_line),
      .line    (edge_lines[k*38 +: 38]),
      .en      (edge_en[k]),
      .sh_en   (sh_mask[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      error      <= 1'b0;
      edge_count <= '0;
      idx        <= '0;
      vcnt       <= '0;
      ovf        <= 1'b0;
      first_x    <= '0;
      first_y    <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
    end else begin
      if (commit) edge_count <= pop;
      if (start) begin
        state <= FIRST;
        error <= 1'b0;
        idx   <= '0;
        vcnt  <= '0;
        ovf   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            idx  <= '0;
            vcnt <= '0;
            ovf  <= 1'b0;
          end
          FIRST: if (accept) begin
            first_x <= vtx_x;
            first_y <= vtx_y;
            prev_x  <= vtx_x;
            prev_y  <= vtx_y;
            vcnt    <= 2'd1;
            if (vtx_last) begin
              error <= 1'b1;
              state <= IDLE;
            end else begin
              state <= COLLECT;
            end
          end
          COLLECT: if (accept) begin
            prev_x <= vtx_x;
            prev_y <= vtx_y;
            if (vcnt != 2'd3) vcnt <= vcnt + 2'd1;
            if (!skip_cur) begin
              if (idx_free) idx <= idx + 1'b1;
              else          ovf <= 1'b1;
            end
            if (vtx_last) state <= CLOSE;
          end
          CLOSE: begin
            if (vcnt != 2'd3 || ovf) begin
              error <= 1'b1;
              state <= IDLE;
            end else if (skip_close) begin
              state <= PENDING;
            end else if (idx_free) begin
              idx   <= idx + 1'b1;
              state <= PENDING;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
          PENDING: if (frame_start) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_polygon_edge_builder.sv
// Directed bench for polygon_edge_builder; a polygon-level model predicts the committed bank.
module tb_polygon_edge_builder;
  localparam int M = 8;
  localparam int CW = $clog2(M+1);

  logic            clk = 0, reset_n = 0;
  logic            start = 0, vtx_valid = 0, vtx_last = 0, frame_start = 0;
  logic [9:0]      vtx_x = '0;
  logic [8:0]      vtx_y = '0;
  logic            vtx_ready, busy, error;
  logic [M*38-1:0] edge_lines;
  logic [M-1:0]    edge_en;
  logic [CW-1:0]   edge_count;

  polygon_edge_builder #(.MAX_EDGES(M)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .vtx_valid(vtx_valid),
    .vtx_ready(vtx_ready), .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_last(vtx_last),
    .frame_start(frame_start), .edge_lines(edge_lines), .edge_en(edge_en),
    .edge_count(edge_count), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit chk_on = 0;

  // expected active bank, and the result predicted for the polygon just sent
  logic [M*38-1:0] exp_lines = '0, pl;
  logic [M-1:0]    exp_en = '0, pe;
  int              exp_cnt = 0, pc;
  bit              perr;

  logic [9:0] qx[$];
  logic [8:0] qy[$];

  localparam logic [37:0] T0 = {10'd100, 9'd50, 10'd200, 9'd50};
  localparam logic [37:0] T1 = {10'd200, 9'd50, 10'd150, 9'd150};
  localparam logic [37:0] T2 = {10'd150, 9'd150, 10'd100, 9'd50};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    tests++;
    if (edge_lines !== exp_lines || edge_en !== exp_en || edge_count !== CW'(exp_cnt)) begin
      fails++;
      $display("FAIL active_bank got lines=%h en=%h cnt=%0d want lines=%h en=%h cnt=%0d",
               edge_lines, edge_en, edge_count, exp_lines, exp_en, exp_cnt);
    end
  end

  // Closed loop v0->v1->...->v(n-1)->v0, packed in order into free slots.
  task automatic model_build();
    int n;
    n = qx.size();
    pl = '0; pe = '0; pc = 0; perr = 0;
    if (n < 3) begin
      perr = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      int j;
      j = (i + 1) % n;
`ifdef POLY_HORIZ_SKIP_EN
      if (qy[i] == qy[j]) continue;
`endif
      if (pc == M) perr = 1;
      else begin
        pl[pc*38 +: 38] = {qx[i], qy[i], qx[j], qy[j]};
        pe[pc] = 1'b1;
        pc++;
      end
    end
  endtask

  task automatic send_poly(input bit flag_last);
    int t;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < qx.size(); i++) begin
      vtx_valid = 1; vtx_x = qx[i]; vtx_y = qy[i];
      vtx_last = flag_last && (i == qx.size() - 1);
      t = 0;
      @(negedge clk);
      while (!vtx_ready && t < 20) begin t++; @(negedge clk); end
      if (!vtx_ready) chk("vtx_ready_timeout", vtx_ready, 1);
      @(posedge clk); #1;
    end
    vtx_valid = 0; vtx_last = 0;
    model_build();
  endtask

  task automatic pulse_frame(input bit expect_commit);
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk);
    if (expect_commit) begin exp_lines = pl; exp_en = pe; exp_cnt = pc; end
    #1 frame_start = 0;
  endtask

  task automatic set_tri();
    qx = '{10'd100, 10'd200, 10'd150};
    qy = '{9'd50, 9'd50, 9'd150};
  endtask

  task automatic check_tri_literals(input string tag);
`ifdef POLY_HORIZ_SKIP_EN
    chk({tag, "_slot0"}, edge_lines[37:0], T1);
    chk({tag, "_slot1"}, edge_lines[75:38], T2);
    chk({tag, "_en"}, edge_en, 8'h03);
    chk({tag, "_cnt"}, edge_count, 2);
`else
    chk({tag, "_slot0"}, edge_lines[37:0], T0);
    chk({tag, "_slot1"}, edge_lines[75:38], T1);
    chk({tag, "_slot2"}, edge_lines[113:76], T2);
    chk({tag, "_en"}, edge_en, 8'h07);
    chk({tag, "_cnt"}, edge_count, 3);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_lines", |edge_lines, 0);
    chk("rst_en", edge_en, 0);
    chk("rst_cnt", edge_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", vtx_ready, 0);
    chk("rst_error", error, 0);
    @(posedge clk); #1 reset_n = 1;
    chk_on = 1;

    // triangle, committed
    set_tri();
    send_poly(1);
    @(posedge clk); #1;
    chk("tri_pending_busy", busy, 1);
    chk("tri_error", error, 0);
    chk("tri_model_err", perr, 0);
    pulse_frame(1);
    @(negedge clk);
    check_tri_literals("tri");
    chk("tri_busy_after", busy, 0);
    chk("tri_error_after", error, 0);

    // quad held 100 cycles before commit
    qx = '{10'd10, 10'd300, 10'd310, 10'd5};
    qy = '{9'd10, 9'd20, 9'd200, 9'd180};
    send_poly(1);
    repeat (100) begin
      @(negedge clk);
      chk("hold_busy", busy, 1);
    end
    pulse_frame(1);
    @(negedge clk);
    chk("quad_slot3", edge_lines[151:114], {10'd5, 9'd180, 10'd10, 9'd10});
    chk("quad_busy", busy, 0);

    // 9 vertices: closing edge has no slot
    qx.delete(); qy.delete();
    for (int i = 0; i < 9; i++) begin
      qx.push_back(10'(i * 10 + 3));
      qy.push_back(9'(i * 7 + 1));
    end
    send_poly(1);
    @(posedge clk); #1;
    chk("ovf_model_err", perr, 1);
    chk("ovf_error", error, 1);
    chk("ovf_busy", busy, 0);
    pulse_frame(0);
    @(negedge clk);
    chk("ovf_en_kept", edge_en, 8'h0f);

    // 2 vertices: rejected, start clears error
    qx = '{10'd10, 10'd20};
    qy = '{9'd10, 9'd20};
    send_poly(1);
    @(posedge clk); #1;
    chk("two_error", error, 1);
    chk("two_busy", busy, 0);
    pulse_frame(0);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("two_err_cleared", error, 0);
    chk("two_first_ready", vtx_ready, 1);

    // start and frame_start together while pending: commit, then FIRST
    set_tri();
    send_poly(1);
    @(posedge clk); #1 start = 1; frame_start = 1;
    @(posedge clk);
    exp_lines = pl; exp_en = pe; exp_cnt = pc;
    #1 start = 0; frame_start = 0;
    chk("sf_busy", busy, 1);
    chk("sf_ready", vtx_ready, 1);
    @(negedge clk);
    check_tri_literals("sf");

    // reset mid-COLLECT clears everything asynchronously
    qx = '{10'd10, 10'd20};
    qy = '{9'd10, 9'd20};
    send_poly(0);
    chk("mid_collect_ready", vtx_ready, 1);
    #2;
    exp_lines = '0; exp_en = '0; exp_cnt = 0;
    reset_n = 0;
    #1;
    chk("arst_lines", |edge_lines, 0);
    chk("arst_en", edge_en, 0);
    chk("arst_cnt", edge_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", vtx_ready, 0);
    @(posedge clk); #1 reset_n = 1;
    set_tri();
    send_poly(1);
    pulse_frame(1);
    @(negedge clk);
    check_tri_literals("post_rst");

    repeat (3) @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
